// File: rtl/qea_run_ctrl.sv
// qea_run_ctrl: run sequencer for the quantum emulation accelerator.
// Takes a run command, streams gate context into ctx RAM, initialises the
// state RAM to |0..0>, starts the engine, times the run, then streams every
// state RAM row out over a valid/ready port.
// Optional watchdog: define QEA_RUN_CTRL_TIMEOUT_EN to abort runs that exceed
// TIMEOUT_CYCLES (reported through o_timeout and a bare o_done pulse).
module qea_run_ctrl #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int CYCLE_CNT_WIDTH         = 32,
  parameter logic [31:0] INIT_AMP       = 32'h40000000,
  parameter int RD_LATENCY              = 1,
  parameter int TIMEOUT_CYCLES          = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
  input  logic                                 i_ctx_valid,
  output logic                                 o_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
  input  logic                                 i_qea_complete,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 o_rd_valid,
  input  logic                                 i_rd_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
  output logic                                 o_rd_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_timeout,
  output logic [CYCLE_CNT_WIDTH-1:0]           o_exec_cycles
);

  localparam int ROW_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int RE_W  = STATE_DATA_WIDTH / 2;
  localparam int LAT_W = $clog2(RD_LATENCY + 1);
  localparam int CAW   = GATE_CONTEXT_ADDR_WIDTH;

  localparam logic [CAW:0]                 CTX_ONE  = (CAW+1)'(1);
  localparam logic [STATE_ADDR_WIDTH-1:0]  ROW_ONE  = STATE_ADDR_WIDTH'(1);
  localparam logic [CYCLE_CNT_WIDTH-1:0]   CNT_ONE  = CYCLE_CNT_WIDTH'(1);
  localparam logic [LAT_W-1:0]             WAIT_ONE = LAT_W'(1);
  localparam logic [LAT_W-1:0]             LAT_LAST = LAT_W'(RD_LATENCY - 1);
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
  localparam logic [CYCLE_CNT_WIDTH-1:0]   TO_LIMIT = CYCLE_CNT_WIDTH'(TIMEOUT_CYCLES);
`endif

  typedef enum logic [3:0] {
    IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE, ERR
  } state_t;

  state_t                        state_q, state_d;
  logic [MAX_QBIT_WIDTH-1:0]     qbit_q, qbit_d;
  logic [CAW:0]                  nwords_q, nwords_d;
  logic [CAW:0]                  ctx_cnt_q, ctx_cnt_d;
  logic [STATE_ADDR_WIDTH-1:0]   row_q, row_d;
  logic [STATE_ADDR_WIDTH-1:0]   last_row_q, last_row_d;
  logic [CYCLE_CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [CYCLE_CNT_WIDTH-1:0]    exec_q, exec_d;
  logic                          first_q, first_d;
  logic [LAT_W-1:0]              wait_q, wait_d;
  logic [ROW_W-1:0]              rd_data_q, rd_data_d;
  logic [CAW:0]                  ins_clamp;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
  logic                          timeout_q, timeout_d;
`endif

  // Index of the last state row: low (qbit - PE_NUM_WIDTH) bits set, which
  // saturates naturally at the full address range.
  function automatic logic [STATE_ADDR_WIDTH-1:0] last_row_of(input logic [MAX_QBIT_WIDTH-1:0] q);
    int unsigned qi;
    int unsigned sh;
    logic [STATE_ADDR_WIDTH-1:0] r;
    qi = int'(q);
    sh = (qi > PE_NUM_WIDTH) ? qi - PE_NUM_WIDTH : 0;
    for (int unsigned b = 0; b < STATE_ADDR_WIDTH; b++) r[b] = (b < sh);
    return r;
  endfunction

  // Next-state and datapath register updates for the run sequence.
  always_comb begin
    state_d    = state_q;
    qbit_d     = qbit_q;
    nwords_d   = nwords_q;
    ctx_cnt_d  = ctx_cnt_q;
    row_d      = row_q;
    last_row_d = last_row_q;
    cnt_d      = cnt_q;
    exec_d     = exec_q;
    first_d    = first_q;
    wait_d     = wait_q;
    rd_data_d  = rd_data_q;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
    timeout_d  = timeout_q;
`endif
    ins_clamp = (i_ins_num[CAW] && (|i_ins_num[CAW-1:0])) ? {1'b1, {CAW{1'b0}}} : i_ins_num;

    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          qbit_d     = i_qbit_num;
          nwords_d   = ins_clamp;
          last_row_d = last_row_of(i_qbit_num);
          ctx_cnt_d  = '0;
          row_d      = '0;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
          timeout_d  = 1'b0;
`endif
          state_d    = (ins_clamp == '0) ? INIT_STATE : LOAD_CTX;
        end
      end
      LOAD_CTX: begin
        if (i_ctx_valid) begin
          ctx_cnt_d = ctx_cnt_q + CTX_ONE;
          if (ctx_cnt_q + CTX_ONE == nwords_q) state_d = INIT_STATE;
        end
      end
      INIT_STATE: begin
        if (row_q == last_row_q) begin
          row_d   = '0;
          cnt_d   = CNT_ONE;
          state_d = START;
        end else begin
          row_d = row_q + ROW_ONE;
        end
      end
      START: begin
        cnt_d   = cnt_q + CNT_ONE;
        exec_d  = '0;
        first_d = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        if (first_q) begin
          first_d = 1'b0;
        end else if (i_qea_complete) begin
          exec_d  = cnt_q;
          row_d   = '0;
          state_d = RD_REQ;
        end
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
        else if (cnt_q >= TO_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ERR;
        end
`endif
      end
      RD_REQ: begin
        wait_d  = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (wait_q == LAT_LAST) begin
          rd_data_d = i_qea_state_dout;
          state_d   = RD_OUT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      RD_OUT: begin
        if (i_rd_ready) begin
          if (row_q == last_row_q) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_ONE;
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      qbit_q     <= '0;
      nwords_q   <= '0;
      ctx_cnt_q  <= '0;
      row_q      <= '0;
      last_row_q <= '0;
      cnt_q      <= '0;
      exec_q     <= '0;
      first_q    <= 1'b0;
      wait_q     <= '0;
      rd_data_q  <= '0;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      qbit_q     <= qbit_d;
      nwords_q   <= nwords_d;
      ctx_cnt_q  <= ctx_cnt_d;
      row_q      <= row_d;
      last_row_q <= last_row_d;
      cnt_q      <= cnt_d;
      exec_q     <= exec_d;
      first_q    <= first_d;
      wait_q     <= wait_d;
      rd_data_q  <= rd_data_d;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Output decode from the registered state; ctx writes pass through in the accept cycle.
  always_comb begin
    o_cmd_ready   = (state_q == IDLE);
    o_ctx_ready   = (state_q == LOAD_CTX);
    o_ctx_en      = (state_q == LOAD_CTX) && i_ctx_valid;
    o_ctx_wea     = o_ctx_en;
    o_ctx_addr    = ctx_cnt_q[CAW-1:0];
    o_ctx_data    = o_ctx_en ? i_ctx_data : '0;
    o_state_ena   = ((state_q == INIT_STATE) || (state_q == RD_REQ)) ? '1 : '0;
    o_state_wea   = (state_q == INIT_STATE) ? '1 : '0;
    o_state_addra = ((state_q == INIT_STATE) || (state_q == RD_REQ)) ? row_q : '0;
    o_state_dina  = '0;
    if ((state_q == INIT_STATE) && (row_q == '0))
      o_state_dina[ROW_W-1 -: RE_W] = RE_W'(INIT_AMP);
    o_qea_start   = (state_q == START);
    o_qbit_num    = qbit_q;
    o_rd_valid    = (state_q == RD_OUT);
    o_rd_data     = rd_data_q;
    o_rd_last     = (state_q == RD_OUT) && (row_q == last_row_q);
    o_busy        = (state_q != IDLE);
    o_done        = (state_q == DONE) || (state_q == ERR);
    o_exec_cycles = exec_q;
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
    o_timeout     = timeout_q;
`else
    o_timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_qea_run_ctrl.sv
// Bench for qea_run_ctrl: directed and randomized runs checked against a
// transaction-level model of ctx loading, state init, timing and readout.
module tb_qea_run_ctrl;
  localparam int CAW = 7;
  localparam int SAW = 3;
  localparam int PEW = 2;
  localparam int PE  = 4;
  localparam int MQ  = 6;
  localparam int RW  = 256;
  localparam int MAXR = 1 << SAW;

  logic clk = 1'b0;
  logic rst;
  logic i_cmd_valid, o_cmd_ready;
  logic [MQ-1:0] i_qbit_num, o_qbit_num;
  logic [CAW:0] i_ins_num;
  logic i_ctx_valid, o_ctx_ready;
  logic [63:0] i_ctx_data, o_ctx_data;
  logic o_qea_start, i_qea_complete;
  logic o_ctx_en, o_ctx_wea;
  logic [CAW-1:0] o_ctx_addr;
  logic [PE-1:0] o_state_ena, o_state_wea;
  logic [SAW-1:0] o_state_addra;
  logic [RW-1:0] o_state_dina, i_qea_state_dout, o_rd_data;
  logic o_rd_valid, i_rd_ready, o_rd_last;
  logic o_busy, o_done, o_timeout;
  logic [31:0] o_exec_cycles;

  int nchecks = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  qea_run_ctrl #(
    .GATE_CONTEXT_ADDR_WIDTH(CAW),
    .STATE_ADDR_WIDTH(SAW),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
    .o_qea_start(o_qea_start), .o_qbit_num(o_qbit_num), .i_qea_complete(i_qea_complete),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .i_qea_state_dout(i_qea_state_dout),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_exec_cycles(o_exec_cycles)
  );

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    nchecks++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: words loaded = ins clipped to ctx depth.
  function automatic int exp_n(input int ins);
    return (ins > (1 << CAW)) ? (1 << CAW) : ins;
  endfunction

  // Model: rows = 2^(qbits - log2 lanes), at least 1, at most state depth.
  function automatic int exp_rows(input int q);
    int sh;
    sh = q - PEW;
    if (sh <= 0) return 1;
    if (sh >= SAW) return MAXR;
    return 1 << sh;
  endfunction

  // One full command. cdelay: cycles after the start pulse at which complete
  // goes (and stays) high, 0 = never. rst_row >= 0 aborts with reset at that
  // init row.
  task automatic run_cmd(input int q, input int ins, input int gap_pct, input int cdelay,
                         input int stall_beat, input int stall_len, input bit pulse1,
                         input int rst_row);
    int n, r, cyc, start_cyc, nstart, ndone, nwr, ninit, nreq, nbeat, stall_cnt, outst, exp_exec;
    bit cmd_taken, got_done, aborted, rd_pending, expect_to;
    logic [2:0] pend_addr;
    logic [RW-1:0] mem [0:MAXR-1];
    logic [RW-1:0] exp_row;
    logic [63:0] words[$];

    n = exp_n(ins);
    r = exp_rows(q);
    expect_to = (cdelay == 0);
    exp_exec = (cdelay >= 2) ? cdelay + 1 : 3;
    for (int i = 0; i < n; i++) words.push_back({$urandom, $urandom});
    for (int i = 0; i < MAXR; i++) mem[i] = '0;
    cyc = 0; start_cyc = -1; nstart = 0; ndone = 0; nwr = 0; ninit = 0; nreq = 0;
    nbeat = 0; stall_cnt = 0; outst = 0;
    cmd_taken = 0; got_done = 0; aborted = 0; rd_pending = 0; pend_addr = '0;

    i_qbit_num = MQ'(q);
    i_ins_num = (CAW+1)'(ins);
    i_cmd_valid = 1'b1;

    while (!got_done && !aborted && cyc < 3000) begin
      @(negedge clk);
      if (cmd_taken) i_cmd_valid = 1'b0;
      i_ctx_valid = (nwr < n) && ($urandom_range(99) >= gap_pct);
      i_ctx_data = (i_ctx_valid && nwr < n) ? words[nwr] : {$urandom, $urandom};
      i_qea_complete = (start_cyc >= 0) &&
                       ((pulse1 && cyc == start_cyc + 1) || (cdelay > 0 && cyc >= start_cyc + cdelay));
      i_qea_state_dout = rd_pending ? mem[pend_addr] : rand_row();
      rd_pending = 0;
      if (nbeat == stall_beat && stall_cnt < stall_len) i_rd_ready = 1'b0;
      else i_rd_ready = ($urandom_range(3) != 0);
      #1;
      if (i_cmd_valid && o_cmd_ready) cmd_taken = 1;
      if (o_ctx_en) begin
        check("ctx_wea", RW'(o_ctx_wea), RW'(1));
        if (nwr < n) begin
          check("ctx_addr", RW'(o_ctx_addr), RW'(nwr));
          check("ctx_data", RW'(o_ctx_data), RW'(words[nwr]));
        end else begin
          check("ctx_overrun", RW'(nwr), RW'(n - 1));
        end
        nwr++;
      end
      if (o_state_ena != '0 && o_state_wea != '0) begin
        exp_row = '0;
        if (ninit == 0) exp_row[RW-1 -: 64] = 64'h40000000_00000000;
        check("init_addr", RW'(o_state_addra), RW'(ninit));
        check("init_ena", RW'({o_state_ena, o_state_wea}), RW'(8'hFF));
        check("init_dina", o_state_dina, exp_row);
        ninit++;
        if (rst_row >= 0 && ninit - 1 == rst_row) begin
          rst = 1'b1;
          aborted = 1;
        end
      end
      if (o_qea_start) begin
        nstart++;
        start_cyc = cyc;
        check("init_rows_at_start", RW'(ninit), RW'(r));
        check("ctx_words_at_start", RW'(nwr), RW'(n));
        for (int i = 0; i < r; i++) mem[i] = rand_row();
      end
      if (o_state_ena != '0 && o_state_wea == '0) begin
        check("rd_req_addr", RW'(o_state_addra), RW'(nbeat));
        check("rd_req_ena", RW'(o_state_ena), RW'(4'hF));
        check("rd_one_outstanding", RW'(outst), RW'(0));
        outst = 1;
        nreq++;
        rd_pending = 1;
        pend_addr = o_state_addra;
      end
      if (o_rd_valid) begin
        check("rd_data", o_rd_data, (nbeat < r) ? mem[nbeat] : '0);
        check("rd_last", RW'(o_rd_last), RW'(nbeat == r - 1));
        if (!i_rd_ready && nbeat == stall_beat) stall_cnt++;
        if (i_rd_ready) begin
          nbeat++;
          outst = 0;
        end
      end
      if (o_done) begin
        ndone++;
        got_done = 1;
      end
      cyc++;
    end

    i_cmd_valid = 1'b0; i_ctx_valid = 1'b0; i_qea_complete = 1'b0; i_rd_ready = 1'b0;

    if (aborted) begin
      @(negedge clk); #1;
      check("rst_ena", RW'({o_state_ena, o_state_wea, o_ctx_en, o_ctx_wea, o_qea_start}), RW'(0));
      check("rst_idle", RW'({o_busy, o_cmd_ready, o_done, o_rd_valid}), RW'(4'b0100));
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        check("post_rst_quiet", RW'({o_busy, o_done, o_state_ena, o_ctx_en}), RW'(0));
      end
    end else begin
      check("cycle_budget", RW'(cyc < 3000), RW'(1));
      check("ctx_writes", RW'(nwr), RW'(n));
      check("init_rows", RW'(ninit), RW'(r));
      check("start_pulses", RW'(nstart), RW'(1));
      check("done_pulses", RW'(ndone), RW'(1));
      check("qbit_out", RW'(o_qbit_num), RW'(q));
      if (expect_to) begin
        check("timeout_flag", RW'(o_timeout), RW'(1));
        check("timeout_beats", RW'(nbeat), RW'(0));
        check("timeout_reads", RW'(nreq), RW'(0));
      end else begin
        check("timeout_flag", RW'(o_timeout), RW'(0));
        check("beats", RW'(nbeat), RW'(r));
        check("exec_cycles", RW'(o_exec_cycles), RW'(exp_exec));
      end
      @(negedge clk); #1;
      check("after_done_idle", RW'({o_busy, o_cmd_ready, o_done}), RW'(3'b010));
    end
  endtask

  initial begin
    rst = 1'b1;
    i_cmd_valid = 0; i_qbit_num = '0; i_ins_num = '0; i_ctx_valid = 0; i_ctx_data = '0;
    i_qea_complete = 0; i_qea_state_dout = '0; i_rd_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", RW'({o_busy, o_done, o_timeout, o_rd_valid, o_rd_last, o_qea_start,
                                o_ctx_en, o_ctx_ready, o_state_ena, o_state_wea}), RW'(0));
    check("reset_exec", RW'(o_exec_cycles), RW'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_release_ready", RW'({o_cmd_ready, o_busy}), RW'(2'b10));

    run_cmd(5, 101, 0, 20, -1, 0, 1'b0, -1);
    run_cmd(2, 0, 0, 5, -1, 0, 1'b0, -1);
    run_cmd(5, 40, 30, 12, 2, 5, 1'b1, -1);
    run_cmd(6, 200, 20, 1, 5, 3, 1'b0, -1);
    run_cmd(5, 10, 0, 8, -1, 0, 1'b0, 4);
    run_cmd(3, 7, 10, 4, -1, 0, 1'b0, -1);
    for (int k = 0; k < 6; k++)
      run_cmd($urandom_range(6), $urandom_range(150), $urandom_range(50), $urandom_range(30, 2),
              $urandom_range(MAXR - 1), $urandom_range(6), 1'($urandom_range(1)), -1);
`ifdef QEA_RUN_CTRL_TIMEOUT_EN
    run_cmd(3, 5, 0, 0, -1, 0, 1'b0, -1);
    run_cmd(4, 3, 0, 6, -1, 0, 1'b0, -1);
`endif

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end
endmodule

// File: doc/qea_run_ctrl.md
QEA_RUN_CTRL -- requirements
Module: qea_run_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  PE_NUM_WIDTH 2, log2 of PE lanes; PE_NUM 4, lanes (=2**PE_NUM_WIDTH); MAX_QBIT_WIDTH 6, qubit-count width
  STATE_DATA_WIDTH 64, complex amplitude {re,im} Q2.30 per lane; STATE_ADDR_WIDTH 16, state RAM row address
  GATE_CONTEXT_DATA_WIDTH 64, ctx word; GATE_CONTEXT_ADDR_WIDTH 16, ctx address; CYCLE_CNT_WIDTH 32, exec counter
  INIT_AMP 32'h40000000, real part of |0..0> amplitude; RD_LATENCY 1, state RAM read latency; TIMEOUT_CYCLES 1000000, watchdog limit
REQ-002 Ports, one per line: name direction width meaning. One clock; reset is synchronous and active-high.
  clk in 1 clock; rst in 1 synchronous active-high reset
  i_cmd_valid in 1 / o_cmd_ready out 1 run-command handshake
  i_qbit_num in MAX_QBIT_WIDTH qubits; i_ins_num in GATE_CONTEXT_ADDR_WIDTH+1 ctx words to load
  i_ctx_valid in 1 / o_ctx_ready out 1 / i_ctx_data in GATE_CONTEXT_DATA_WIDTH ctx stream
  o_qea_start out 1; o_qbit_num out MAX_QBIT_WIDTH; i_qea_complete in 1
  o_ctx_en, o_ctx_wea out 1; o_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; o_ctx_data out GATE_CONTEXT_DATA_WIDTH
  o_state_ena, o_state_wea out PE_NUM; o_state_addra out STATE_ADDR_WIDTH; o_state_dina out PE_NUM*STATE_DATA_WIDTH
  i_qea_state_dout in PE_NUM*STATE_DATA_WIDTH
  o_rd_valid out 1 / i_rd_ready in 1 / o_rd_data out PE_NUM*STATE_DATA_WIDTH / o_rd_last out 1 readout stream
  o_busy out 1; o_done out 1 (pulse); o_timeout out 1; o_exec_cycles out CYCLE_CNT_WIDTH

Function
REQ-003 FSM states: IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_REQ, RD_WAIT, RD_OUT, DONE, ERR.
REQ-004 IDLE: o_cmd_ready=1; cmd accepted on i_cmd_valid&o_cmd_ready; i_qbit_num, i_ins_num latched; o_qbit_num driven from latch until next accept.
REQ-005 LOAD_CTX: o_ctx_ready=1; each accepted word written same cycle (o_ctx_en=o_ctx_wea=1), address 0,1,..,N-1; stall without write when i_ctx_valid=0.
REQ-006 N = min(i_ins_num, 2**GATE_CONTEXT_ADDR_WIDTH); N=0 skips LOAD_CTX.
REQ-007 Rows R = 2**(qbit_num-PE_NUM_WIDTH), R=1 when qbit_num<=PE_NUM_WIDTH, saturated at 2**STATE_ADDR_WIDTH.
REQ-008 INIT_STATE: one row per cycle, addr 0..R-1, ena=wea=all ones; row 0 most-significant lane = {INIT_AMP, 0}, all other lanes/rows zero.
REQ-009 START: o_qea_start=1 exactly one cycle; counter cleared to 1 in this cycle.
REQ-010 RUN: counter increments per cycle; i_qea_complete ignored in the cycle after START, sampled from the second cycle after START onward; on first sampled 1 counter frozen into o_exec_cycles, go RD_REQ.
REQ-011 Readout per row: RD_REQ drives ena=all ones, wea=0, addr=row (1 cycle); RD_WAIT holds RD_LATENCY cycles; capture i_qea_state_dout into o_rd_data; RD_OUT holds o_rd_valid=1, data stable until i_rd_ready.
REQ-012 o_rd_last=1 with row R-1; after its handshake go DONE.
REQ-013 DONE: o_done=1 one cycle, return IDLE; o_exec_cycles held until next START.
REQ-014 o_busy=1 in every state except IDLE.
REQ-015 Counter saturates at all ones, no wrap.
REQ-016 o_ctx_en/wea, o_state_ena/wea, o_qea_start are 0 in every state not listed as driving them.

Reset
REQ-017 On rst at clk edge: state IDLE; every output 0 except o_cmd_ready=1 after reset release; o_exec_cycles=0.
REQ-018 rst mid-operation aborts immediately; no further RAM write or read issued; no o_done.

Configuration
REQ-019 Macro QEA_RUN_CTRL_TIMEOUT_EN defined: RUN counting TIMEOUT_CYCLES without complete -> ERR; ERR sets o_timeout=1 (sticky until next cmd accept), o_done=1 one cycle, no readout, back to IDLE.
REQ-020 Macro undefined: RUN waits indefinitely; o_timeout tied 0; no watchdog logic.

Verification
REQ-021 qbit=5, N=101, ctx stream no gaps -> 101 writes addr 0..100 data in order, 8 init rows, row0 lane3=64'h40000000_00000000.
REQ-022 complete rises 20 cycles after start pulse -> o_exec_cycles=21, 8 readout beats, o_rd_last on beat 8, o_done pulse.
REQ-023 qbit=2, N=0 -> no ctx writes, R=1 single init row and single readout beat with o_rd_last.
REQ-024 i_rd_ready low 5 cycles on beat 3 -> o_rd_data stable, no new RAM read issued until handshake.
REQ-025 rst asserted during INIT_STATE row 4 -> next cycle all enables 0, state IDLE, no o_done.
REQ-026 QEA_RUN_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=50, complete never set -> o_timeout=1, o_done pulse, zero readout beats.
